// File: rtl/i2c_target_ctrl.sv
// I2C target engine: decodes the bus, matches DEV_ADDR, keeps a register pointer and strobes a register bank.
// Optional: define I2C_GLITCH_FILTER_EN for a 3-sample filter on SCL/SDA (pad-to-event latency 6 clk instead of 3).
module i2c_target_ctrl #(
    parameter logic [6:0]  DEV_ADDR = 7'h70,
    parameter int unsigned ADDR_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              busy
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK
    } state_t;

    state_t     state;
    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_now;
    logic       sda_now;
    logic       scl_prev;
    logic       sda_prev;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;
    logic [7:0] shift;
    logic [3:0] bit_cnt;
    logic       rw;
    logic       mack;

    // NOTE: every sequential block uses non-blocking assignments so each branch reads pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] scl_hist;
    logic [1:0] sda_hist;
    logic       scl_flt;
    logic       sda_flt;

    // A new level is accepted only after three consecutive equal synced samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
            scl_flt  <= 1'b1;
            sda_flt  <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
            if ({scl_hist, scl_sync[1]} == 3'b111) begin
                scl_flt <= 1'b1;
            end else if ({scl_hist, scl_sync[1]} == 3'b000) begin
                scl_flt <= 1'b0;
            end
            if ({sda_hist, sda_sync[1]} == 3'b111) begin
                sda_flt <= 1'b1;
            end else if ({sda_hist, sda_sync[1]} == 3'b000) begin
                sda_flt <= 1'b0;
            end
        end
    end

    assign scl_now = scl_flt;
    assign sda_now = sda_flt;
`else
    assign scl_now = scl_sync[1];
    assign sda_now = sda_sync[1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_prev <= scl_now;
            sda_prev <= sda_now;
        end
    end

    assign scl_rise  = scl_now & ~scl_prev;
    assign scl_fall  = ~scl_now & scl_prev;
    assign start_det = scl_now & sda_prev & ~sda_now;
    assign stop_det  = scl_now & ~sda_prev & sda_now;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sda_oe    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= 8'h00;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            busy      <= 1'b0;
            shift     <= 8'h00;
            bit_cnt   <= 4'd0;
            rw        <= 1'b0;
            mack      <= 1'b1;
        end else begin
            reg_we <= 1'b0;
            reg_re <= 1'b0;

            if (reg_we) begin
                reg_addr <= reg_addr + 1'b1;
            end

            // Read data is taken in the strobe cycle, when reg_addr already points at the new register.
            if (reg_re) begin
                shift  <= reg_rdata;
                sda_oe <= ~reg_rdata[7];
            end

            if (stop_det) begin
                state   <= IDLE;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
                bit_cnt <= 4'd0;
            end else if (start_det) begin
                state   <= ADDR;
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
            end else if (scl_rise) begin
                case (state)
                    ADDR, PTR, WDATA: begin
                        if (bit_cnt != 4'd8) begin
                            shift   <= {shift[6:0], sda_now};
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    RDATA: begin
                        if (bit_cnt != 4'd8) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    RDATA_ACK: mack <= sda_now;
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state)
                    ADDR: begin
                        if (bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            if (shift[7:1] == DEV_ADDR) begin
                                sda_oe <= 1'b1;
                                busy   <= 1'b1;
                                rw     <= shift[0];
                                state  <= ADDR_ACK;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= IDLE;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        bit_cnt <= 4'd0;
                        if (rw) begin
                            reg_re <= 1'b1;
                            state  <= RDATA;
                        end else begin
                            sda_oe <= 1'b0;
                            state  <= PTR;
                        end
                    end
                    PTR: begin
                        if (bit_cnt == 4'd8) begin
                            bit_cnt  <= 4'd0;
                            reg_addr <= shift[ADDR_W-1:0];
                            sda_oe   <= 1'b1;
                            state    <= PTR_ACK;
                        end
                    end
                    PTR_ACK: begin
                        bit_cnt <= 4'd0;
                        sda_oe  <= 1'b0;
                        state   <= WDATA;
                    end
                    WDATA: begin
                        if (bit_cnt == 4'd8) begin
                            bit_cnt   <= 4'd0;
                            reg_wdata <= shift;
                            reg_we    <= 1'b1;
                            sda_oe    <= 1'b1;
                            state     <= WDATA_ACK;
                        end
                    end
                    WDATA_ACK: begin
                        bit_cnt <= 4'd0;
                        sda_oe  <= 1'b0;
                        state   <= WDATA;
                    end
                    RDATA: begin
                        if (bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            sda_oe  <= 1'b0;
                            state   <= RDATA_ACK;
                        end else if (bit_cnt != 4'd0) begin
                            shift  <= {shift[6:0], 1'b0};
                            sda_oe <= ~shift[6];
                        end
                    end
                    RDATA_ACK: begin
                        bit_cnt  <= 4'd0;
                        reg_addr <= reg_addr + 1'b1;
                        if (!mack) begin
                            reg_re <= 1'b1;
                            state  <= RDATA;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_ctrl.sv
// Bench for i2c_target_ctrl: acts as I2C master and register bank, checks strobes against a transaction-level model.
`timescale 1ns/1ps
module tb_i2c_target_ctrl;

    localparam int ADDR_W = 3;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk   = 1'b0;
    logic              rst   = 1'b1;
    logic              scl_m = 1'b1;
    logic              sda_m = 1'b1;
    logic              sda_bus;
    logic              sda_oe;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_we;
    logic              reg_re;
    logic [7:0]        reg_rdata;
    logic              busy;

    logic [7:0] bank  [DEPTH] = '{default: 8'h00};
    logic [7:0] m_mem [DEPTH] = '{default: 8'h00};
    int         m_ptr = 0;
    logic [ADDR_W-1:0] exp_w_addr [$];
    logic [7:0]        exp_w_data [$];
    logic [ADDR_W-1:0] exp_r_addr [$];
    logic              quiet = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Open-drain bus: the line is low if either side pulls it.
    assign sda_bus   = sda_m & ~sda_oe;
    assign reg_rdata = bank[reg_addr];

    always @(posedge clk) begin
        if (reg_we) bank[reg_addr] <= reg_wdata;
    end

    i2c_target_ctrl #(
        .DEV_ADDR (7'h70),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_m),
        .sda_i     (sda_bus),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_set_ptr(input logic [7:0] b);
        m_ptr = int'(b) % DEPTH;
    endfunction

    function automatic void model_write(input logic [7:0] d);
        exp_w_addr.push_back(ADDR_W'(m_ptr));
        exp_w_data.push_back(d);
        m_mem[m_ptr] = d;
        m_ptr = (m_ptr + 1) % DEPTH;
    endfunction

    function automatic logic [7:0] model_read();
        logic [7:0] d;
        exp_r_addr.push_back(ADDR_W'(m_ptr));
        d = m_mem[m_ptr];
        m_ptr = (m_ptr + 1) % DEPTH;
        return d;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (reg_we || reg_re) check("strobe_exclusive", reg_we & reg_re, 0);
            if (reg_we) begin
                check("we_expected", exp_w_addr.size() != 0, 1);
                if (exp_w_addr.size() != 0) begin
                    check("we_addr", reg_addr, exp_w_addr.pop_front());
                    check("we_data", reg_wdata, exp_w_data.pop_front());
                end
            end
            if (reg_re) begin
                check("re_expected", exp_r_addr.size() != 0, 1);
                if (exp_r_addr.size() != 0) check("re_addr", reg_addr, exp_r_addr.pop_front());
            end
            if (quiet) check("quiet_sda_oe", sda_oe, 0);
        end
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SCL period (8 clk low, 8 clk high); optional 2-clk low glitch on SDA mid-high.
    task automatic bit_cycle(input logic b, input logic glitch, output logic seen);
        clks(4);
        sda_m = b;
        clks(4);
        scl_m = 1'b1;
        clks(2);
        if (glitch) begin
            sda_m = 1'b0;
            clks(2);
            sda_m = b;
        end else begin
            clks(2);
        end
        @(negedge clk);
        seen = sda_bus;
        clks(4);
        scl_m = 1'b0;
    endtask

    task automatic start_cond();
        clks(4);
        sda_m = 1'b0;
        clks(8);
        scl_m = 1'b0;
    endtask

    task automatic rstart_cond();
        clks(4);
        sda_m = 1'b1;
        clks(4);
        scl_m = 1'b1;
        clks(4);
        sda_m = 1'b0;
        clks(4);
        scl_m = 1'b0;
    endtask

    task automatic stop_cond();
        clks(4);
        sda_m = 1'b0;
        clks(4);
        scl_m = 1'b1;
        clks(4);
        sda_m = 1'b1;
        clks(8);
    endtask

    task automatic send_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
        logic seen;
        for (int i = 0; i < 8; i++) bit_cycle(b[7-i], i == glitch_bit, seen);
        bit_cycle(1'b1, 1'b0, ack);
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] d);
        logic seen;
        for (int i = 0; i < 8; i++) begin
            bit_cycle(1'b1, 1'b0, seen);
            d[7-i] = seen;
        end
        bit_cycle(mack, 1'b0, seen);
    endtask

    task automatic write_tx(input string tag, input logic [7:0] ptr, input logic [15:0] data, input int n);
        logic       ack;
        logic [7:0] d;
        start_cond();
        send_byte(8'hE0, -1, ack);
        check({tag, "_addr_ack"}, ack, 0);
        check({tag, "_busy_set"}, busy, 1);
        model_set_ptr(ptr);
        send_byte(ptr, -1, ack);
        check({tag, "_ptr_ack"}, ack, 0);
        for (int i = 0; i < n; i++) begin
            d = (n == 2 && i == 0) ? data[15:8] : data[7:0];
            model_write(d);
            send_byte(d, -1, ack);
            check({tag, "_data_ack"}, ack, 0);
        end
        stop_cond();
        check({tag, "_busy_clr"}, busy, 0);
        check({tag, "_sda_rel"}, sda_oe, 0);
        check({tag, "_ptr"}, reg_addr, m_ptr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic       seen;
        logic [7:0] rd;
        logic [7:0] exp0;
        logic [7:0] exp1;
        int         w;

        clks(3);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_we", reg_we, 0);
        check("rst_re", reg_re, 0);
        check("rst_addr", reg_addr, 0);
        check("rst_wdata", reg_wdata, 0);
        rst = 1'b0;
        clks(4);

        // Plain write of one byte to register 2.
        write_tx("t1", 8'h02, 16'h00A5, 1);
        check("t1_addr_lit", reg_addr, 3);
        check("t1_wdata_lit", reg_wdata, 8'hA5);
        check("t1_bank2_lit", bank[2], 8'hA5);

        // Wrong device address: never drives SDA.
        quiet = 1'b1;
        start_cond();
        send_byte(8'hE2, -1, ack);
        check("t2_addr_nack", ack, 1);
        send_byte(8'h55, -1, ack);
        check("t2_data_nack", ack, 1);
        stop_cond();
        quiet = 1'b0;
        check("t2_busy", busy, 0);
        check("t2_ptr_kept", reg_addr, 3);

        // Load reg7/reg0 through a wrapping write, then read them back with a repeated START.
        write_tx("t3w", 8'h07, 16'h3CC3, 2);
        check("t3w_ptr_lit", reg_addr, 1);
        start_cond();
        send_byte(8'hE0, -1, ack);
        check("t3_addr_ack", ack, 0);
        model_set_ptr(8'h07);
        send_byte(8'h07, -1, ack);
        check("t3_ptr_ack", ack, 0);
        rstart_cond();
        exp0 = model_read();
        exp1 = model_read();
        send_byte(8'hE1, -1, ack);
        check("t3_raddr_ack", ack, 0);
        recv_byte(1'b0, rd);
        check("t3_rd0", rd, exp0);
        check("t3_rd0_lit", rd, 8'h3C);
        recv_byte(1'b1, rd);
        check("t3_rd1", rd, exp1);
        check("t3_rd1_lit", rd, 8'hC3);
        stop_cond();
        check("t3_ptr_lit", reg_addr, 1);
        check("t3_busy", busy, 0);

        // STOP after four data bits; pointer upper bits ignored.
        start_cond();
        send_byte(8'hE0, -1, ack);
        check("t4_addr_ack", ack, 0);
        model_set_ptr(8'hFD);
        send_byte(8'hFD, -1, ack);
        check("t4_ptr_ack", ack, 0);
        for (int i = 0; i < 4; i++) bit_cycle(i[0] == 1'b0, 1'b0, seen);
        stop_cond();
        check("t4_ptr_lit", reg_addr, 5);
        check("t4_sda_oe", sda_oe, 0);
        check("t4_busy", busy, 0);

        // Short low pulse on SDA while SCL is high in the middle of a data byte.
        start_cond();
        send_byte(8'hE0, -1, ack);
        check("t6_addr_ack", ack, 0);
        model_set_ptr(8'h04);
        send_byte(8'h04, -1, ack);
        check("t6_ptr_ack", ack, 0);
`ifdef I2C_GLITCH_FILTER_EN
        model_write(8'hFF);
        send_byte(8'hFF, 3, ack);
        check("t6_data_ack", ack, 0);
        stop_cond();
        check("t6_ptr_lit", reg_addr, 5);
`else
        send_byte(8'hFF, 3, ack);
        check("t6_data_nack", ack, 1);
        stop_cond();
        check("t6_ptr_lit", reg_addr, 4);
`endif
        check("t6_ptr", reg_addr, m_ptr);
        check("t6_busy", busy, 0);

        // Reset while the address ACK is being driven.
        start_cond();
        for (int i = 0; i < 8; i++) bit_cycle(i < 3, 1'b0, seen);
        w = 0;
        while (sda_oe !== 1'b1 && w < 8) begin
            clks(1);
            w++;
        end
        check("t5_ack_driven", sda_oe, 1);
        rst   = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t5_sda_oe", sda_oe, 0);
        check("t5_busy", busy, 0);
        check("t5_we", reg_we, 0);
        check("t5_re", reg_re, 0);
        check("t5_addr", reg_addr, 0);
        check("t5_wdata", reg_wdata, 0);
        m_ptr = 0;
        clks(3);
        rst = 1'b0;
        clks(4);
        write_tx("t5b", 8'h02, 16'h00A5, 1);
        check("t5b_addr_lit", reg_addr, 3);

        check("w_queue_empty", exp_w_addr.size(), 0);
        check("r_queue_empty", exp_r_addr.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
